vend_txn_sequencer: RTL and testbench
=====================================

Name: vend_txn_sequencer

Overview:
Transaction controller placed in front of the product dispenser and the Rs.5 change hopper.
- Takes product selection and coin events, accumulates credit and checks it against a fixed price table.
- Sequences the dispense handshake, then pays out change one Rs.5 coin per hopper handshake.
- Handles cancel/timeout refunds and coin rejection so the dispenser and hopper only ever see legal requests.

Parameters:
CREDIT_W, 6, credit register width in rupees
MAX_CREDIT, 20, highest credit accepted; a coin that would exceed it is rejected
TIMEOUT_CYC, 1024, idle cycles in COLLECT before an automatic refund
STOCK_INIT, 8, initial per-product stock (used only with STOCK_TRACK_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
choice_valid  in  1  choice qualifier, one-cycle pulse
choice  in  2  01 = product 1 (Rs.10), 10 = product 2 (Rs.5); others invalid
coin_valid  in  1  coin event qualifier, one-cycle pulse
coin  in  4  0101 = Rs.5, 1010 = Rs.10; others invalid
cancel  in  1  user refund request, pulse
dispense_req  out  1  dispense request, level
dispense_prod  out  2  product being dispensed; valid while dispense_req = 1
dispense_done  in  1  dispenser completion, pulse
change_req  out  1  request one Rs.5 coin from hopper, level
change_done  in  1  hopper paid one coin, pulse
coin_reject  out  1  coin returned to user, one-cycle pulse
vend_done  out  1  transaction complete, one-cycle pulse
credit  out  CREDIT_W  current credit in rupees
busy  out  1  high in every state except IDLE
states  out  3  current state code, for debug
sold_out  out  1  selection refused, pulse (feature only)
restock  in  1  reload stock counters (feature only)

Behaviour:
- Reset (reset = 0, asynchronous):
  - State IDLE; credit = 0.
  - dispense_req, change_req, coin_reject, vend_done, sold_out = 0; dispense_prod = 00.
  - Reset mid-transaction discards credit with no refund; the outstanding handshake is abandoned.
- All outputs are registered. Every input event takes effect in the cycle after it is sampled.
- States: IDLE = 000, COLLECT = 001, VEND = 010, CHANGE = 011.
- IDLE:
  - choice_valid with a valid choice: latch product and price (Rs.10 or Rs.5), go to COLLECT.
  - An invalid choice is ignored.
  - coin_valid: coin_reject pulse; credit stays 0.
- COLLECT:
  - Valid coin: if credit + value <= MAX_CREDIT, credit += value; otherwise coin_reject pulse.
  - Invalid coin code: coin_reject pulse.
  - Each accepted coin reloads the timeout counter.
  - Once registered credit >= price: go to VEND, drive dispense_req = 1 and dispense_prod = latched product.
  - cancel, or timeout expiry: go to CHANGE, refunding the full credit; if credit = 0, go straight to IDLE.
  - Coin and cancel in the same cycle: the coin is accepted first, then the refund includes it.
  - cancel in the same cycle that credit reaches price: cancel wins and no dispense occurs.
  - choice_valid in COLLECT is ignored.
- VEND:
  - dispense_req holds until dispense_done.
  - On dispense_done: dispense_req = 0, credit -= price, vend_done pulse.
  - Then go to CHANGE if credit > 0, else IDLE.
  - Coins are rejected; cancel and choice are ignored.
- CHANGE:
  - change_req = 1 while credit > 0.
  - Each change_done: credit -= 5.
  - When credit reaches 0: change_req drops in the same registered update, go to IDLE.
  - Coins are rejected.
- Handshake rules:
  - A done pulse arriving while its req is low is ignored.
  - dispense_done and change_done are never both legal in the same cycle.
- Arithmetic and invariants:
  - Credit stays a multiple of 5; an underflow guard saturates it at 0.
  - Refund/change coin count = credit / 5.

Optional Feature:
STOCK_TRACK_EN:
- Defined:
  - One CREDIT_W-independent 4-bit stock counter per product, reset to STOCK_INIT.
  - Selecting a product with stock 0 gives a sold_out pulse and the FSM stays in IDLE.
  - dispense_done decrements the counter of the dispensed product.
  - restock (in IDLE) reloads all counters to STOCK_INIT.
- Undefined: sold_out is tied to 0, restock is unused, and every valid choice is accepted.

Decomposition:
- Package vend_pkg holds:
  - coin codes COIN_5 = 4'b0101, COIN_10 = 4'b1010;
  - choice codes CH_P1 = 2'b01, CH_P2 = 2'b10;
  - PRICE_P1 = 10, PRICE_P2 = 5, CHANGE_UNIT = 5;
  - state enum vend_state_t.
- One sub-module, vend_timeout_timer: loadable down-counter with clear, load and expired pulse, sized from TIMEOUT_CYC.

Test Plan:
1. Choose 01, insert 1010 -> dispense_req with dispense_prod = 01; dispense_done -> vend_done pulse, credit 0, IDLE, change_req never asserted.
2. Choose 10, insert 1010 -> dispense, then one change_req/change_done cycle with credit 5 -> 0, then IDLE.
3. Choose 01, insert 0101 then cancel -> CHANGE, one Rs.5 coin refunded, no dispense_req.
4. Choose 01; insert 0111 -> coin_reject; insert 0101 x2 -> credit 10 and dispense. Coin during VEND -> coin_reject, credit unchanged.
5. Choose 01, insert 0101, wait TIMEOUT_CYC cycles -> auto refund of Rs.5. Separately, assert reset in the middle of CHANGE -> all outputs 0, IDLE.
6. With STOCK_TRACK_EN and STOCK_INIT = 1: buy product 2 once; select 10 again -> sold_out pulse, stays IDLE; restock, select 10 -> accepted, enters COLLECT.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared codes, prices and state encoding for the vending transaction sequencer.
package vend_pkg;

   localparam logic [3:0] COIN_5  = 4'b0101;
   localparam logic [3:0] COIN_10 = 4'b1010;

   localparam logic [1:0] CH_P1 = 2'b01;
   localparam logic [1:0] CH_P2 = 2'b10;

   localparam int unsigned PRICE_P1    = 10;
   localparam int unsigned PRICE_P2    = 5;
   localparam int unsigned CHANGE_UNIT = 5;

   typedef enum logic [2:0] {
      IDLE    = 3'b000,
      COLLECT = 3'b001,
      VEND    = 3'b010,
      CHANGE  = 3'b011
   } vend_state_t;

   // Rupee value of a coin code; 0 marks an unrecognised code.
   function automatic int unsigned coin_value(input logic [3:0] c);
      case (c)
         COIN_5:  return 5;
         COIN_10: return 10;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/vend_timeout_timer.sv
// Idle timeout down-counter: load restarts the window, expired_c flags its last cycle.
module vend_timeout_timer #(
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic load,
   input  logic en,
   output logic expired_c
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= RELOAD;
      end else if (clear) begin
         cnt <= '0;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // A reload in the same cycle always beats expiry.
   assign expired_c = en && !load && (cnt == '0);

endmodule

// File: rtl/vend_txn_sequencer.sv
// Vending transaction sequencer: credit collection, dispense and change handshakes.
// Define STOCK_TRACK_EN to add per-product stock counters with sold_out/restock.
module vend_txn_sequencer
   import vend_pkg::*;
#(
   parameter int unsigned CREDIT_W    = 6,
   parameter int unsigned MAX_CREDIT  = 20,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned STOCK_INIT  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                choice_valid,
   input  logic [1:0]          choice,
   input  logic                coin_valid,
   input  logic [3:0]          coin,
   input  logic                cancel,
   output logic                dispense_req,
   output logic [1:0]          dispense_prod,
   input  logic                dispense_done,
   output logic                change_req,
   input  logic                change_done,
   output logic                coin_reject,
   output logic                vend_done,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy,
   output logic [2:0]          states,
   output logic                sold_out,
   input  logic                restock
);

   localparam int unsigned SUM_W = CREDIT_W + 1;
   localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_CREDIT);

   vend_state_t         state, state_n;
   logic [1:0]          prod_q, prod_n;
   logic [CREDIT_W-1:0] price_q, price_n;
   logic [CREDIT_W-1:0] credit_n, coin_val;
   logic [SUM_W-1:0]    coin_sum;
   logic                coin_ok;
   logic                dreq_n, creq_n, reject_n, vdone_n, sold_n;
   logic [1:0]          dprod_n;
   logic                tmr_load_c, tmr_expired_c, in_stock_c;

   function automatic logic [CREDIT_W-1:0] sat_sub(input logic [CREDIT_W-1:0] a,
                                                   input logic [CREDIT_W-1:0] b);
      return (a >= b) ? (a - b) : '0;
   endfunction

   vend_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear     (state != COLLECT),
      .load      (tmr_load_c),
      .en        (state == COLLECT),
      .expired_c (tmr_expired_c)
   );

`ifdef STOCK_TRACK_EN
   logic [3:0] stock_p1, stock_p2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stock_p1 <= 4'(STOCK_INIT);
         stock_p2 <= 4'(STOCK_INIT);
      end else if ((state == IDLE) && restock) begin
         stock_p1 <= 4'(STOCK_INIT);
         stock_p2 <= 4'(STOCK_INIT);
      end else if ((state == VEND) && dispense_req && dispense_done) begin
         if ((prod_q == CH_P1) && (stock_p1 != 4'd0)) stock_p1 <= stock_p1 - 4'd1;
         if ((prod_q == CH_P2) && (stock_p2 != 4'd0)) stock_p2 <= stock_p2 - 4'd1;
      end
   end

   assign in_stock_c = (choice == CH_P1) ? (stock_p1 != 4'd0) : (stock_p2 != 4'd0);
`else
   logic [4:0] unused_feature;
   assign unused_feature = {restock, 4'(STOCK_INIT)};
   assign in_stock_c     = 1'b1;
`endif

   // Next state and next registered outputs.
   always_comb begin
      state_n    = state;
      prod_n     = prod_q;
      price_n    = price_q;
      credit_n   = credit;
      dreq_n     = dispense_req;
      dprod_n    = dispense_prod;
      creq_n     = change_req;
      reject_n   = 1'b0;
      vdone_n    = 1'b0;
      sold_n     = 1'b0;
      tmr_load_c = 1'b0;
      coin_val   = CREDIT_W'(coin_value(coin));
      coin_sum   = SUM_W'(credit) + SUM_W'(coin_val);
      coin_ok    = (coin_val != '0) && (coin_sum <= MAX_SUM);

      case (state)
         IDLE: begin
            if (coin_valid) reject_n = 1'b1;
            if (choice_valid && ((choice == CH_P1) || (choice == CH_P2))) begin
               if (!in_stock_c) begin
                  sold_n = 1'b1;
               end else begin
                  prod_n     = choice;
                  price_n    = (choice == CH_P1) ? CREDIT_W'(PRICE_P1) : CREDIT_W'(PRICE_P2);
                  state_n    = COLLECT;
                  tmr_load_c = 1'b1;
               end
            end
         end

         COLLECT: begin
            if (coin_valid) begin
               if (coin_ok) begin
                  credit_n   = coin_sum[CREDIT_W-1:0];
                  tmr_load_c = 1'b1;
               end else begin
                  reject_n = 1'b1;
               end
            end
            // Refund takes priority over dispensing and includes a coin accepted this cycle.
            if (cancel || tmr_expired_c) begin
               if (credit_n == '0) begin
                  state_n = IDLE;
               end else begin
                  state_n = CHANGE;
                  creq_n  = 1'b1;
               end
            end else if (credit >= price_q) begin
               state_n = VEND;
               dreq_n  = 1'b1;
               dprod_n = prod_q;
            end
         end

         VEND: begin
            if (coin_valid) reject_n = 1'b1;
            if (dispense_done && dispense_req) begin
               dreq_n   = 1'b0;
               dprod_n  = 2'b00;
               vdone_n  = 1'b1;
               credit_n = sat_sub(credit, price_q);
               if (credit_n != '0) begin
                  state_n = CHANGE;
                  creq_n  = 1'b1;
               end else begin
                  state_n = IDLE;
               end
            end
         end

         CHANGE: begin
            if (coin_valid) reject_n = 1'b1;
            if (credit == '0) begin
               creq_n  = 1'b0;
               state_n = IDLE;
            end else if (change_done && change_req) begin
               credit_n = sat_sub(credit, CREDIT_W'(CHANGE_UNIT));
               if (credit_n == '0) begin
                  creq_n  = 1'b0;
                  state_n = IDLE;
               end
            end
         end

         default: begin
            state_n  = IDLE;
            credit_n = '0;
            dreq_n   = 1'b0;
            dprod_n  = 2'b00;
            creq_n   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         prod_q        <= 2'b00;
         price_q       <= '0;
         credit        <= '0;
         dispense_req  <= 1'b0;
         dispense_prod <= 2'b00;
         change_req    <= 1'b0;
         coin_reject   <= 1'b0;
         vend_done     <= 1'b0;
         sold_out      <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_n;
         prod_q        <= prod_n;
         price_q       <= price_n;
         credit        <= credit_n;
         dispense_req  <= dreq_n;
         dispense_prod <= dprod_n;
         change_req    <= creq_n;
         coin_reject   <= reject_n;
         vend_done     <= vdone_n;
         sold_out      <= sold_n;
         busy          <= (state_n != IDLE);
      end
   end

   assign states = state;

endmodule

// File: tb/tb_vend_txn_sequencer.sv
// Directed bench for vend_txn_sequencer: handshake events go through an expected/observed scoreboard.
module tb_vend_txn_sequencer;
   import vend_pkg::*;

   localparam int unsigned TO = 40;
`ifdef STOCK_TRACK_EN
   localparam int unsigned STOCK = 1;
`else
   localparam int unsigned STOCK = 8;
`endif

   localparam logic [3:0] EV_DISP  = 4'h1;
   localparam logic [3:0] EV_VDONE = 4'h2;
   localparam logic [3:0] EV_CREQ  = 4'h3;
   localparam logic [3:0] EV_REJ   = 4'h4;
   localparam logic [3:0] EV_COIN  = 4'h5;
   localparam logic [3:0] EV_SOLD  = 4'h6;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       choice_valid = 1'b0;
   logic [1:0] choice = 2'b00;
   logic       coin_valid = 1'b0;
   logic [3:0] coin = 4'b0000;
   logic       cancel = 1'b0;
   logic       dispense_done = 1'b0;
   logic       change_done = 1'b0;
   logic       restock = 1'b0;
   logic       dispense_req, change_req, coin_reject, vend_done, busy, sold_out;
   logic [1:0] dispense_prod;
   logic [5:0] credit;
   logic [2:0] states;

   int passed = 0;
   int fails  = 0;
   int total  = 0;

   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   logic       prev_dreq = 1'b0;
   logic       prev_creq = 1'b0;

   vend_txn_sequencer #(
      .CREDIT_W    (6),
      .MAX_CREDIT  (20),
      .TIMEOUT_CYC (TO),
      .STOCK_INIT  (STOCK)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .choice_valid  (choice_valid),
      .choice        (choice),
      .coin_valid    (coin_valid),
      .coin          (coin),
      .cancel        (cancel),
      .dispense_req  (dispense_req),
      .dispense_prod (dispense_prod),
      .dispense_done (dispense_done),
      .change_req    (change_req),
      .change_done   (change_done),
      .coin_reject   (coin_reject),
      .vend_done     (vend_done),
      .credit        (credit),
      .busy          (busy),
      .states        (states),
      .sold_out      (sold_out),
      .restock       (restock)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish before 500000");
      $fatal(1, "watchdog");
   end

   // Observe DUT events mid-cycle; inputs change just after the rising edge.
   always @(negedge clk) begin
      if (!reset) begin
         prev_dreq <= 1'b0;
         prev_creq <= 1'b0;
      end else begin
         if (dispense_req && !prev_dreq) obs_q.push_back({EV_DISP, 2'b00, dispense_prod});
         if (vend_done)                  obs_q.push_back({EV_VDONE, 4'h0});
         if (change_req && !prev_creq)   obs_q.push_back({EV_CREQ, 4'h0});
         if (coin_reject)                obs_q.push_back({EV_REJ, 4'h0});
         if (change_req && change_done)  obs_q.push_back({EV_COIN, 4'h0});
         if (sold_out)                   obs_q.push_back({EV_SOLD, 4'h0});
         prev_dreq <= dispense_req;
         prev_creq <= change_req;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] outs_vec();
      return 32'({states, credit, dispense_req, dispense_prod, change_req,
                  coin_reject, vend_done, busy, sold_out});
   endfunction

   task automatic expect_ev(input logic [3:0] t, input logic [1:0] d);
      exp_q.push_back({t, 2'b00, d});
   endtask

   task automatic sb_check(input string tag);
      logic [7:0] e, o;
      @(negedge clk);
      #1;
      chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      while ((exp_q.size() > 0) && (obs_q.size() > 0)) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         chk({tag, "_event"}, 32'(o), 32'(e));
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic choose(input logic [1:0] c);
      choice_valid = 1'b1;
      choice       = c;
      cyc();
      choice_valid = 1'b0;
      choice       = 2'b00;
   endtask

   task automatic insert(input logic [3:0] c);
      coin_valid = 1'b1;
      coin       = c;
      cyc();
      coin_valid = 1'b0;
      coin       = 4'b0000;
   endtask

   task automatic do_cancel();
      cancel = 1'b1;
      cyc();
      cancel = 1'b0;
   endtask

   task automatic serve_dispense();
      int i = 0;
      while (!dispense_req && (i < 20)) begin
         cyc();
         i++;
      end
      chk("dispense_req_seen", 32'(dispense_req), 32'd1);
      dispense_done = 1'b1;
      cyc();
      dispense_done = 1'b0;
   endtask

   task automatic serve_change();
      int budget = 20;
      while (change_req && (budget > 0)) begin
         change_done = 1'b1;
         cyc();
         change_done = 1'b0;
         cyc();
         budget--;
      end
      chk("change_req_dropped", 32'(change_req), 32'd0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outs_vec(), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cyc();
      chk("idle_after_reset", outs_vec(), 32'd0);

      // IDLE corner cases
      choose(2'b11);
      chk("invalid_choice_ignored", 32'(states), 32'd0);
      insert(COIN_10);
      expect_ev(EV_REJ, 2'b00);
      chk("idle_coin_credit", 32'(credit), 32'd0);
      dispense_done = 1'b1;
      change_done   = 1'b1;
      cyc();
      dispense_done = 1'b0;
      change_done   = 1'b0;
      chk("stray_done_ignored", 32'(states), 32'd0);
      choose(CH_P1);
      chk("collect_state", 32'(states), 32'd1);
      chk("collect_busy", 32'(busy), 32'd1);
      do_cancel();
      chk("cancel_zero_credit_idle", 32'(states), 32'd0);
      sb_check("t0");

      // Product 1 exact payment
      choose(CH_P1);
      insert(COIN_10);
      chk("t1_credit", 32'(credit), 32'd10);
      expect_ev(EV_DISP, CH_P1);
      expect_ev(EV_VDONE, 2'b00);
      serve_dispense();
      chk("t1_credit_after", 32'(credit), 32'd0);
      chk("t1_idle", 32'(states), 32'd0);
      sb_check("t1");

      // Product 2 with one coin of change
      choose(CH_P2);
      insert(COIN_10);
      expect_ev(EV_DISP, CH_P2);
      expect_ev(EV_VDONE, 2'b00);
      expect_ev(EV_CREQ, 2'b00);
      expect_ev(EV_COIN, 2'b00);
      serve_dispense();
      chk("t2_credit_change", 32'(credit), 32'd5);
      chk("t2_change_state", 32'(states), 32'd3);
      serve_change();
      chk("t2_credit_end", 32'(credit), 32'd0);
      chk("t2_idle", 32'(states), 32'd0);
      sb_check("t2");

      // Cancel refund
      choose(CH_P1);
      insert(COIN_5);
      do_cancel();
      expect_ev(EV_CREQ, 2'b00);
      expect_ev(EV_COIN, 2'b00);
      chk("t3_change_state", 32'(states), 32'd3);
      chk("t3_refund_credit", 32'(credit), 32'd5);
      serve_change();
      chk("t3_idle", 32'(states), 32'd0);
      sb_check("t3");

      // Invalid coin, two Rs.5 coins, coin during VEND
      choose(CH_P1);
      insert(4'b0111);
      expect_ev(EV_REJ, 2'b00);
      insert(COIN_5);
      insert(COIN_5);
      chk("t4_credit", 32'(credit), 32'd10);
      cyc();
      chk("t4_dispense_prod", 32'({dispense_req, dispense_prod}), 32'({1'b1, CH_P1}));
      expect_ev(EV_DISP, CH_P1);
      insert(COIN_5);
      expect_ev(EV_REJ, 2'b00);
      chk("t4_vend_credit_held", 32'(credit), 32'd10);
      chk("t4_vend_state", 32'(states), 32'd2);
      expect_ev(EV_VDONE, 2'b00);
      serve_dispense();
      chk("t4_credit_end", 32'(credit), 32'd0);
      sb_check("t4");

      // Coin that would exceed MAX_CREDIT is rejected
      choose(CH_P1);
      insert(COIN_5);
      insert(COIN_10);
      insert(COIN_10);
      chk("t4b_credit_capped", 32'(credit), 32'd15);
      expect_ev(EV_DISP, CH_P1);
      expect_ev(EV_REJ, 2'b00);
      expect_ev(EV_VDONE, 2'b00);
      expect_ev(EV_CREQ, 2'b00);
      expect_ev(EV_COIN, 2'b00);
      serve_dispense();
      chk("t4b_change_credit", 32'(credit), 32'd5);
      serve_change();
      sb_check("t4b");

      // Coin landing exactly on MAX_CREDIT is accepted
      choose(CH_P1);
      insert(COIN_5);
      insert(COIN_10);
      insert(COIN_5);
      chk("t4c_credit_max", 32'(credit), 32'd20);
      expect_ev(EV_DISP, CH_P1);
      expect_ev(EV_VDONE, 2'b00);
      expect_ev(EV_CREQ, 2'b00);
      expect_ev(EV_COIN, 2'b00);
      expect_ev(EV_COIN, 2'b00);
      serve_dispense();
      chk("t4c_change_credit", 32'(credit), 32'd10);
      serve_change();
      chk("t4c_idle", 32'(states), 32'd0);
      sb_check("t4c");

      // Cancel in the cycle credit reaches price wins
      choose(CH_P2);
      insert(COIN_5);
      do_cancel();
      expect_ev(EV_CREQ, 2'b00);
      expect_ev(EV_COIN, 2'b00);
      chk("cancel_wins_state", 32'(states), 32'd3);
      chk("cancel_wins_no_disp", 32'(dispense_req), 32'd0);
      serve_change();
      sb_check("cancel_wins");

      // Coin and cancel together: refund includes the coin
      choose(CH_P1);
      coin_valid = 1'b1;
      coin       = COIN_5;
      cancel     = 1'b1;
      cyc();
      coin_valid = 1'b0;
      coin       = 4'b0000;
      cancel     = 1'b0;
      expect_ev(EV_CREQ, 2'b00);
      expect_ev(EV_COIN, 2'b00);
      chk("coin_cancel_credit", 32'(credit), 32'd5);
      chk("coin_cancel_state", 32'(states), 32'd3);
      serve_change();
      sb_check("coin_cancel");

      // Timeout refund exactly TO cycles after the last accepted coin
      choose(CH_P1);
      insert(COIN_5);
      repeat (TO - 1) cyc();
      chk("t5_before_timeout", 32'(states), 32'd1);
      cyc();
      chk("t5_timeout_state", 32'(states), 32'd3);
      chk("t5_timeout_credit", 32'(credit), 32'd5);
      expect_ev(EV_CREQ, 2'b00);
      expect_ev(EV_COIN, 2'b00);
      serve_change();
      sb_check("t5");

      // Reset in the middle of CHANGE
      choose(CH_P1);
      insert(COIN_5);
      do_cancel();
      expect_ev(EV_CREQ, 2'b00);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("t5b_async_reset", outs_vec(), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cyc();
      chk("t5b_idle_after", outs_vec(), 32'd0);
      sb_check("t5b");

`ifdef STOCK_TRACK_EN
      choose(CH_P2);
      insert(COIN_5);
      expect_ev(EV_DISP, CH_P2);
      expect_ev(EV_VDONE, 2'b00);
      serve_dispense();
      choose(CH_P2);
      expect_ev(EV_SOLD, 2'b00);
      chk("t6_sold_out_pulse", 32'(sold_out), 32'd1);
      chk("t6_stays_idle", 32'(states), 32'd0);
      restock = 1'b1;
      cyc();
      restock = 1'b0;
      choose(CH_P2);
      chk("t6_restocked_collect", 32'(states), 32'd1);
      do_cancel();
      chk("t6_idle", 32'(states), 32'd0);
      sb_check("t6");
`else
      choose(CH_P2);
      insert(COIN_5);
      expect_ev(EV_DISP, CH_P2);
      expect_ev(EV_VDONE, 2'b00);
      serve_dispense();
      choose(CH_P2);
      chk("t6_accept_again", 32'(states), 32'd1);
      chk("t6_no_sold_out", 32'(sold_out), 32'd0);
      do_cancel();
      sb_check("t6");
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
